// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers: default exception
// vector width, bit positions of each exception flag, and the vector type.
package pipe_pkg;

  localparam int EXC_W_DEF = 7;

  // Bit positions inside the exception-flag vector.
  localparam int EXC_TRAP       = 0;
  localparam int EXC_IF_ADDR    = 1;
  localparam int EXC_RI         = 2;
  localparam int EXC_OVERFLOW   = 3;
  localparam int EXC_SOFT_INT   = 4;
  localparam int EXC_LOAD_ADDR  = 5;
  localparam int EXC_STORE_ADDR = 6;

  typedef logic [EXC_W_DEF-1:0] exc_vec_t;

endpackage

// File: rtl/pipe_stage_skid_slot.sv
// pipe_slot: one valid+payload+exception register.
//   load : capture d_data/d_exc and mark valid
//   drop : mark empty (slot handed its beat on, nothing replaces it)
//   kill : mark empty and clear the exception bits (flush)
// Priority is reset > kill > load > drop. The payload only changes on load,
// so bubbles never toggle the wide data bus.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int EXC_W       = EXC_W_DEF,
  parameter bit RST_PAYLOAD = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              drop,
  input  logic              kill,
  input  logic [DATA_W-1:0] d_data,
  input  logic [EXC_W-1:0]  d_exc,
  output logic              q_valid,
  output logic [DATA_W-1:0] q_data,
  output logic [EXC_W-1:0]  q_exc
);

  logic              valid_reg;
  logic [DATA_W-1:0] data_reg;
  logic [EXC_W-1:0]  exc_reg;

  // Valid flag and exception bits: cleared by reset and by kill.
  always_ff @(posedge clk) begin
    if (!rst_n || kill) begin
      valid_reg <= 1'b0;
      exc_reg   <= '0;
    end else if (load) begin
      valid_reg <= 1'b1;
      exc_reg   <= d_exc;
    end else if (drop) begin
      valid_reg <= 1'b0;
    end
  end

  // Payload: optionally cleared on reset, otherwise written only on load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if (RST_PAYLOAD) begin
        data_reg <= '0;
      end
    end else if (load && !kill) begin
      data_reg <= d_data;
    end
  end

  assign q_valid = valid_reg;
  assign q_data  = data_reg;
  assign q_exc   = exc_reg;

endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline register with a 2-entry skid buffer
// (main slot drives the outputs, skid slot catches the beat accepted while
// main is stalled). in_ready is registered (!skid_valid), so there is no
// combinational path from out_ready to in_ready.
// Optional feature macro: PIPE_STAGE_PERF_EN adds stall_cnt / drop_cnt.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int EXC_W       = EXC_W_DEF,
  parameter bit RST_PAYLOAD = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [EXC_W-1:0]  in_exc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [EXC_W-1:0]  out_exc,
  output logic              out_exc_any
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [15:0]       drop_cnt
`endif
);

  logic              main_valid;
  logic [DATA_W-1:0] main_data;
  logic [EXC_W-1:0]  main_exc;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [EXC_W-1:0]  skid_exc;

  logic              acc;
  logic              main_adv;
  logic              main_from_skid;
  logic              main_from_in;
  logic              main_load;
  logic              main_drop;
  logic              skid_load;
  logic              skid_drop;
  logic [DATA_W-1:0] main_d_data;
  logic [EXC_W-1:0]  main_d_exc;

  assign in_ready = ~skid_valid;
  assign acc      = in_valid & in_ready;

  // Main advances when it is empty or its beat is being taken downstream.
  assign main_adv       = ~main_valid | out_ready;
  // A beat waiting in skid is always older than the input, so it goes first.
  assign main_from_skid = main_adv & skid_valid;
  assign main_from_in   = main_adv & ~skid_valid & acc;
  assign main_load      = ~flush & (main_from_skid | main_from_in);
  assign main_drop      = ~flush & main_adv & ~skid_valid & ~acc;
  // acc implies skid is empty, so an accepted beat lands in skid only when
  // main is held.
  assign skid_load      = ~flush & acc & ~main_adv;
  assign skid_drop      = ~flush & main_from_skid;

  assign main_d_data = skid_valid ? skid_data : in_data;
  assign main_d_exc  = skid_valid ? skid_exc  : in_exc;

  pipe_slot #(
    .DATA_W      (DATA_W),
    .EXC_W       (EXC_W),
    .RST_PAYLOAD (RST_PAYLOAD)
  ) u_main (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (main_load),
    .drop    (main_drop),
    .kill    (flush),
    .d_data  (main_d_data),
    .d_exc   (main_d_exc),
    .q_valid (main_valid),
    .q_data  (main_data),
    .q_exc   (main_exc)
  );

  pipe_slot #(
    .DATA_W      (DATA_W),
    .EXC_W       (EXC_W),
    .RST_PAYLOAD (RST_PAYLOAD)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (skid_load),
    .drop    (skid_drop),
    .kill    (flush),
    .d_data  (in_data),
    .d_exc   (in_exc),
    .q_valid (skid_valid),
    .q_data  (skid_data),
    .q_exc   (skid_exc)
  );

  assign out_valid   = main_valid;
  assign out_data    = main_data;
  assign out_exc     = main_exc;
  assign out_exc_any = main_valid & (|main_exc);

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt_reg;
  logic [15:0] drop_cnt_reg;

  // Stall counter: cycles a beat is offered but not taken, saturating.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
    end else if (main_valid && !out_ready && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  // Drop counter: flushes that actually killed a beat, wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_cnt_reg <= '0;
    end else if (flush && (main_valid || skid_valid)) begin
      drop_cnt_reg <= drop_cnt_reg + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign drop_cnt  = drop_cnt_reg;
`endif

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised pipeline stage register with a valid/ready handshake.
- Successor to the fixed, always-advancing stage registers of the 5-stage MIPS core.
- Carries an opaque payload bus plus an exception-flag vector, with a 2-entry skid buffer.
- Supports stall (back-pressure) and flush (kill) without combinational ready paths from downstream to upstream.
- Instantiated between IF/ID/EX/MEM/WB stages; payload packing is done by the instantiating stage.

Parameters:
- DATA_W, 32, payload width in bits (must be >= 1).
- EXC_W, 7, exception-flag vector width (trap, IF_addr, ri, overflow, soft_int, load_addr, store_addr).
- RST_PAYLOAD, 1, 1 = payload registers cleared on reset; 0 = only valid and exception bits cleared.

Ports:
- clk, input, 1, clock, rising edge.
- rst_n, input, 1, synchronous active-low reset.
- in_valid, input, 1, upstream has a beat.
- in_ready, output, 1, stage can accept a beat (registered, equals !skid_valid).
- in_data, input, DATA_W, upstream payload.
- in_exc, input, EXC_W, upstream exception flags.
- flush, input, 1, synchronous kill of all held beats.
- out_valid, output, 1, main register holds a beat.
- out_ready, input, 1, downstream accepts.
- out_data, output, DATA_W, held payload.
- out_exc, output, EXC_W, held exception flags.
- out_exc_any, output, 1, OR-reduction of out_exc gated by out_valid.

Behaviour:
- Storage: main slot {main_valid, main_data, main_exc}; skid slot {skid_valid, skid_data, skid_exc}. out_* are driven directly from the main slot.
- Accept condition: acc = in_valid & in_ready. Release condition: rel = out_valid & out_ready.
- Load condition: main loads when !main_valid | out_ready.
  - Source is the skid slot if skid_valid, else the input (only when acc).
  - main_valid next = skid_valid | acc. Skid empties when it is the source.
- Skid fill: when acc and main is not loading from the input (main held, or main loading from skid), the beat goes to the skid slot and skid_valid is set.
- Full: skid_valid=1 gives in_ready=0 next cycle. in_valid is ignored; no beat is lost or duplicated.
- Latency and throughput:
  - 1 cycle from acceptance to out_valid.
  - Sustained 1 beat/cycle with out_ready=1.
  - After a stall, the skid drains first, preserving order.
- Flush:
  - Clears main_valid, skid_valid, main_exc and skid_exc at the clock edge.
  - An input beat presented in the same cycle is dropped, though in_ready reports honestly.
  - Flush has priority over accept and release. Next cycle: out_valid=0, in_ready=1.
- out_exc_any = out_valid & |out_exc. Exception bits travel with their beat; no merging across beats.
- Reset (rst_n=0 at the edge): main_valid=0, skid_valid=0, exc=0, payload=0 if RST_PAYLOAD.
  - Outputs after reset: out_valid=0, out_exc=0, out_exc_any=0, in_ready=1, out_data=0 (if RST_PAYLOAD).
  - Reset mid-stall discards both held beats.
- Payload registers update only on load (no toggling on bubbles).
- X on in_data while in_valid=0 must not propagate to out_data.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- Enabled:
  - Adds output stall_cnt [31:0]: increments each cycle with out_valid & !out_ready, saturates at 0xFFFFFFFF.
  - Adds output drop_cnt [15:0]: increments on each flush that kills at least one valid beat, wraps.
  - Both counters clear on reset and do not clear on flush.
- Disabled: ports and counter logic are absent; datapath behaviour is identical.

Decomposition:
- Shared package pipe_pkg holds:
  - EXC_W default and exception bit index constants (EXC_TRAP=0 .. EXC_STORE_ADDR=6).
  - A typedef of the exception vector.
- One sub-module, pipe_slot: a single valid+data+exc register with load/clear enables, instantiated twice (main, skid).

Test Plan:
- Streaming: out_ready=1, in_valid=1 for 8 beats with data 0x1..0x8 -> out_data 0x1..0x8 on consecutive cycles starting 1 cycle later; in_ready stays 1.
- Stall: beats 0xA, 0xB, 0xC offered while out_ready=0 from cycle 1 -> 0xA held on out, 0xB in skid, in_ready=0, 0xC not accepted until release; after out_ready=1, output order is 0xA, 0xB, 0xC with no gaps.
- Flush with full skid -> next cycle out_valid=0, in_ready=1; the beat 0xD offered in the flush cycle never appears; drop_cnt=1 when PIPE_STAGE_PERF_EN is defined.
- Exception: in_exc=7'b0000100 on beat 0x5 -> out_exc=0x04 and out_exc_any=1 only while 0x5 is valid; the following clean beat shows out_exc=0.
- Reset asserted mid-stall with 2 beats held -> after the edge: out_valid=0, in_ready=1, out_exc=0, out_data=0; stall_cnt=0.
- Random valid/ready (10k cycles) against a scoreboard FIFO -> no loss, duplication or reordering; stall_cnt equals the counted out_valid & !out_ready cycles.
